// File: rtl/dbus_sram_resp.sv
// rtl/dbus_sram_resp.sv - dbus slave modelling a byte-strobed 64-bit SRAM with fixed latency
package dbus_pkg;
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

module dbus_sram_resp
    import dbus_pkg::*;
#(
    parameter int          DEPTH   = 1024,
    parameter int          LATENCY = 2,
    parameter logic [63:0] BASE    = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  dbus_req_t   dreq,
    output dbus_resp_t  dresp,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic        proto_err
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [63:0] SPAN     = 64'(DEPTH) << 3;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [63:0] addr_q, data_q;
    logic [7:0]  strb_q;
    msize_t      size_q;

    logic [63:0] acc_addr, acc_data, off;
    logic [7:0]  acc_strb;
    logic        in_range, fire, viol;
    logic [AW-1:0] idx;

    logic [63:0] mem [DEPTH];

    // Size is kept for completeness; lane extraction belongs to the initiator.
    logic unused_size;
    assign unused_size = ^size_q;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: if (dreq.valid) begin
                cnt_n   = CNT_INIT;
                state_n = (LATENCY == 1) ? RESP : WAIT;
            end
            WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) state_n = RESP;
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // With LATENCY==1 the access happens on the accepting edge, before the latches are loaded.
    always_comb begin
        acc_addr = (state == IDLE) ? dreq.addr   : addr_q;
        acc_strb = (state == IDLE) ? dreq.strobe : strb_q;
        acc_data = (state == IDLE) ? dreq.data   : data_q;
        off      = acc_addr - BASE;
        in_range = (acc_addr >= BASE) && (off < SPAN);
        idx      = off[AW+2:3];
        fire     = (state != RESP) && (state_n == RESP);
        viol     = ((state == WAIT) || (state == RESP)) &&
                   (!dreq.valid || (dreq.addr != addr_q) ||
                    (dreq.strobe != strb_q) || (dreq.data != data_q));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
            data_q <= '0;
            strb_q <= '0;
            size_q <= MSIZE1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (state == IDLE && dreq.valid) begin
                addr_q <= dreq.addr;
                data_q <= dreq.data;
                strb_q <= dreq.strobe;
                size_q <= dreq.size;
            end
        end
    end

    // The RAM write sits under the reset branch so an access can never commit while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dresp     <= '0;
            rd_count  <= '0;
            wr_count  <= '0;
            proto_err <= 1'b0;
        end else begin
            dresp.addr_ok <= fire;
            dresp.data_ok <= fire;
            proto_err     <= proto_err | viol;
            if (fire) begin
                if (acc_strb == 8'h00) begin
                    dresp.data <= in_range ? mem[idx] : 64'h0;
                    rd_count   <= rd_count + 32'd1;
                end else begin
                    dresp.data <= 64'h0;
                    wr_count   <= wr_count + 32'd1;
                    if (in_range) begin
                        for (int i = 0; i < 8; i++) begin
                            if (acc_strb[i]) mem[idx][8*i +: 8] <= acc_data[8*i +: 8];
                        end
                    end
                end
            end
        end
    end
endmodule

// File: doc/dbus_sram_resp.md
Name: dbus_sram_resp

Overview:
- Data-bus responder for the pipeline memory stage. It accepts dbus_req_t requests, models a byte-strobed 64-bit-wide SRAM with a fixed access latency, and returns dbus_resp_t.
- It is the slave end of the dbus that the memory stage drives. Bench and simulation top-level instantiate it in place of the external memory.
- It also keeps access counters and a sticky protocol-violation flag for the verification environment.

Parameters:
- DEPTH, 1024, number of 64-bit words. Power of two, ≥2.
- LATENCY, 2, cycles from acceptance to data_ok. Range 1..15.
- BASE, 64'h8000_0000, byte address of word 0. Must be 8-byte aligned.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- dreq  input  dbus_req_t  request: valid, addr[63:0], size (msize_t), strobe[7:0], data[63:0].
- dresp  output  dbus_resp_t  response: addr_ok, data_ok, data[63:0].
- rd_count  output  32  completed reads (strobe==0).
- wr_count  output  32  completed writes (strobe!=0).
- proto_err  output  1  sticky: the initiator violated the hold rule.

Behaviour:
- Reset (reset low, async): state IDLE; dresp all zero; rd_count=0; wr_count=0; proto_err=0; latch registers zero.
  - RAM contents are not reset; the bench preloads them via hierarchical access.
- Handshake: the initiator holds valid, addr, size, strobe and data stable from assertion until the cycle in which data_ok=1, and may drop valid in the following cycle.
  - addr_ok and data_ok assert together, for exactly one cycle per request.
- FSM, all outputs registered:
  - IDLE: if dreq.valid, latch addr/size/strobe/data and load cnt=LATENCY-1. If LATENCY==1 go to RESP, else go to WAIT.
  - WAIT: decrement cnt each cycle; at cnt==1 go to RESP.
  - RESP: dresp.addr_ok=1 and dresp.data_ok=1 for one cycle; dresp.data holds read data; return to IDLE.
  - Cycle timing: a request accepted in cycle t has data_ok high in cycle t+LATENCY.
- Back-to-back: a request is never accepted in a RESP cycle. IDLE samples valid on the next cycle, so the minimum spacing between data_ok pulses is LATENCY+1 cycles.
- Access is performed at the WAIT/IDLE→RESP transition using the latched values. Word index = (addr-BASE)>>3; addr[2:0] is ignored for indexing.
- Read (strobe==0): dresp.data = the full aligned 64-bit word, unshifted. The initiator does lane extraction using addr[2:0] and size.
- Write (strobe!=0): byte i written from data[8i+7:8i] iff strobe[i]. Data is already lane-shifted by the initiator. dresp.data=0 on writes.
- Out of range (addr<BASE or addr≥BASE+DEPTH*8):
  - Read returns 64'h0.
  - Write is dropped.
  - Handshake and counters behave normally.
- Counters increment in the RESP cycle and wrap at 2^32-1→0.
- proto_err is set while in WAIT or RESP if dreq.valid==0, or if addr, strobe or data differ from the latched values. It stays set until reset.
  - The in-flight request still completes with the latched values.
- dresp.data holds its last value outside RESP, but is only meaningful when data_ok=1.
- Reset asserted mid-request: the FSM returns to IDLE immediately. No data_ok is issued, and a write not yet committed is lost.

Test Plan:
- Read latency: preload word[0]=64'h1122334455667788, LATENCY=2; valid read at 0x8000_0000 accepted in cycle t → data_ok/addr_ok high only in cycle t+2, data=64'h1122334455667788, rd_count=1.
- Byte-strobe write: write addr 0x8000_0003, strobe 8'h08, data 64'hAA<<24 over word 64'h0 → subsequent read returns 64'h0000_0000_AA00_0000; wr_count=1.
- Full-word write/read with LATENCY=1: write 64'hDEADBEEF_CAFEF00D strobe 8'hFF, then read → data_ok one cycle after each acceptance; read data matches; valid held continuously gives data_ok pulses 2 cycles apart.
- Out of range: read at 0x7FFF_FFF8 → data=0, data_ok after LATENCY; write at BASE+DEPTH*8 leaves all words unchanged; counters increment.
- Protocol violation: drop valid in WAIT → proto_err=1 and stays 1; data_ok still occurs at t+LATENCY with the latched-address data.
- Reset mid-request: assert reset (low) in WAIT of a write → dresp=0, counters=0 asynchronously; no data_ok afterwards; target word unchanged.
